// File: rtl/move_sequencer.sv
// Ultimate tic-tac-toe move sequencer: validates a cursor move, commits the mark,
// resolves sub-board and meta-board wins, and keeps per-player match tallies.
module move_sequencer #(
    parameter int WINS_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              move,
    input  logic              new_game,
    input  logic [3:0]        currBoard,
    input  logic [3:0]        currTile,
    output logic [80:0]       X_state,
    output logic [80:0]       O_state,
    output logic [8:0]        board_won_x,
    output logic [8:0]        board_won_o,
    output logic [3:0]        forced_board,
    output logic              turn_o,
    output logic              busy,
    output logic              move_ok,
    output logic              move_err,
    output logic              game_over,
    output logic [1:0]        winner,
    output logic [WINS_W-1:0] numWinsX,
    output logic [WINS_W-1:0] numWinsO,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_VALIDATE   = 3'd1,
        S_COMMIT     = 3'd2,
        S_SUB_CHECK  = 3'd3,
        S_META_CHECK = 3'd4
    } state_t;

    localparam logic [3:0] FREE_BOARD = 4'd9;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_board;
    logic [3:0]        r_tile;
    logic [80:0]       r_x;
    logic [80:0]       r_o;
    logic [8:0]        r_won_x;
    logic [8:0]        r_won_o;
    logic [3:0]        r_forced;
    logic              r_turn_o;
    logic              r_game_over;
    logic [1:0]        r_winner;
    logic [WINS_W-1:0] r_wins_x;
    logic [WINS_W-1:0] r_wins_o;

    logic              w_coords_ok;
    logic [3:0]        w_b;
    logic [3:0]        w_t;
    logic [6:0]        w_base;
    logic [6:0]        w_idx;
    logic [8:0]        w_closed;
    logic              w_forced_ok;
    logic              w_legal;
    logic [8:0]        w_sub_mine;
    logic              w_sub_line;
    logic [8:0]        w_meta_mine;
    logic              w_meta_line;
    logic              w_game_end;
    logic              w_move_ok;
    logic              w_move_err;

    // Tiles are numbered row*3+col inside a 3x3 grid.
    function automatic logic has_line(input logic [8:0] c);
        return (c[0] & c[1] & c[2]) | (c[3] & c[4] & c[5]) | (c[6] & c[7] & c[8]) |
               (c[0] & c[3] & c[6]) | (c[1] & c[4] & c[7]) | (c[2] & c[5] & c[8]) |
               (c[0] & c[4] & c[8]) | (c[2] & c[4] & c[6]);
    endfunction

    // Out-of-range coordinates are clamped so indexing stays in bounds; such moves are rejected anyway.
    assign w_coords_ok = (r_board <= 4'd8) && (r_tile <= 4'd8);
    assign w_b         = w_coords_ok ? r_board : 4'd0;
    assign w_t         = w_coords_ok ? r_tile  : 4'd0;
    assign w_base      = 7'(w_b) * 7'd9;
    assign w_idx       = w_base + 7'(w_t);

    always_comb begin
        w_closed = '0;
        for (int i = 0; i < 9; i++) begin
            w_closed[i] = r_won_x[i] | r_won_o[i] | (&(r_x[i*9 +: 9] | r_o[i*9 +: 9]));
        end
    end

    assign w_forced_ok = (r_forced == FREE_BOARD) || (r_board == r_forced);
    assign w_legal     = w_coords_ok && !r_game_over && !r_x[w_idx] && !r_o[w_idx] &&
                         !w_closed[w_b] && w_forced_ok;

    // Each check reads the registers written one state earlier, so a state's effect is visible in that state.
    assign w_sub_mine  = r_turn_o ? r_o[w_base +: 9] : r_x[w_base +: 9];
    assign w_sub_line  = has_line(w_sub_mine) && !r_won_x[w_b] && !r_won_o[w_b];
    assign w_meta_mine = r_turn_o ? r_won_o : r_won_x;
    assign w_meta_line = has_line(w_meta_mine);
    assign w_game_end  = w_meta_line || (&w_closed);

    // Handshake: move is a request pulse taken only while busy is low; each accepted request is
    // answered by exactly one move_ok or move_err pulse unless new_game or rst aborts it first;
    // requests arriving while busy are dropped without any response.
    always_comb begin
        w_next     = r_state;
        w_move_ok  = 1'b0;
        w_move_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (move) w_next = S_VALIDATE;
            end
            S_VALIDATE: begin
                if (w_legal) begin
                    w_next = S_COMMIT;
                end else begin
                    w_next     = S_IDLE;
                    w_move_err = 1'b1;
                end
            end
            S_COMMIT:     w_next = S_SUB_CHECK;
            S_SUB_CHECK:  w_next = S_META_CHECK;
            S_META_CHECK: begin
                w_next    = S_IDLE;
                w_move_ok = 1'b1;
            end
            default:      w_next = S_IDLE;
        endcase
        if (new_game) begin
            w_next     = S_IDLE;
            w_move_ok  = 1'b0;
            w_move_err = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_board     <= '0;
            r_tile      <= '0;
            r_x         <= '0;
            r_o         <= '0;
            r_won_x     <= '0;
            r_won_o     <= '0;
            r_forced    <= FREE_BOARD;
            r_turn_o    <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= 2'b00;
            r_wins_x    <= '0;
            r_wins_o    <= '0;
        end else if (new_game) begin
            r_x         <= '0;
            r_o         <= '0;
            r_won_x     <= '0;
            r_won_o     <= '0;
            r_forced    <= FREE_BOARD;
            r_turn_o    <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (move) begin
                        r_board <= currBoard;
                        r_tile  <= currTile;
                    end
                end
                S_VALIDATE: begin
                    if (w_legal) begin
                        if (r_turn_o) r_o[w_idx] <= 1'b1;
                        else          r_x[w_idx] <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    if (w_sub_line) begin
                        if (r_turn_o) r_won_o[w_b] <= 1'b1;
                        else          r_won_x[w_b] <= 1'b1;
                    end
                end
                S_SUB_CHECK: begin
                    if (w_meta_line) begin
                        r_game_over <= 1'b1;
                        if (r_turn_o) begin
                            r_winner <= 2'b10;
                            if (r_wins_o != {WINS_W{1'b1}}) r_wins_o <= r_wins_o + 1'b1;
                        end else begin
                            r_winner <= 2'b01;
                            if (r_wins_x != {WINS_W{1'b1}}) r_wins_x <= r_wins_x + 1'b1;
                        end
                    end else if (&w_closed) begin
                        r_game_over <= 1'b1;
                        r_winner    <= 2'b11;
                    end
                    r_forced <= (w_game_end || w_closed[w_t]) ? FREE_BOARD : w_t;
                    r_turn_o <= ~r_turn_o;
                end
                default: ;
            endcase
        end
    end

    assign X_state      = r_x;
    assign O_state      = r_o;
    assign board_won_x  = r_won_x;
    assign board_won_o  = r_won_o;
    assign forced_board = r_forced;
    assign turn_o       = r_turn_o;
    assign busy         = (r_state != S_IDLE);
    assign move_ok      = w_move_ok;
    assign move_err     = w_move_err;
    assign game_over    = r_game_over;
    assign winner       = r_winner;
    assign numWinsX     = r_wins_x;
    assign numWinsO     = r_wins_o;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: a reference game model predicts every
// move outcome and board state; a monitor pops expected outcomes from a queue.
module tb_move_sequencer;

    localparam int WINS_W = 7;
    localparam int WMAX   = (1 << WINS_W) - 1;

    logic              clk;
    logic              rst;
    logic              move;
    logic              new_game;
    logic [3:0]        currBoard;
    logic [3:0]        currTile;
    logic [80:0]       X_state;
    logic [80:0]       O_state;
    logic [8:0]        board_won_x;
    logic [8:0]        board_won_o;
    logic [3:0]        forced_board;
    logic              turn_o;
    logic              busy;
    logic              move_ok;
    logic              move_err;
    logic              game_over;
    logic [1:0]        winner;
    logic [WINS_W-1:0] numWinsX;
    logic [WINS_W-1:0] numWinsO;
    logic [2:0]        dbg_state;

    move_sequencer #(.WINS_W(WINS_W)) dut (
        .clk(clk), .rst(rst), .move(move), .new_game(new_game),
        .currBoard(currBoard), .currTile(currTile),
        .X_state(X_state), .O_state(O_state),
        .board_won_x(board_won_x), .board_won_o(board_won_o),
        .forced_board(forced_board), .turn_o(turn_o), .busy(busy),
        .move_ok(move_ok), .move_err(move_err), .game_over(game_over),
        .winner(winner), .numWinsX(numWinsX), .numWinsO(numWinsO),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] exp_q[$];   // 1 = move_ok expected, 2 = move_err expected

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model
    logic [80:0] m_x, m_o;
    logic [8:0]  m_wx, m_wo;
    int          m_forced;
    bit          m_turn, m_go;
    logic [1:0]  m_winner;
    int          m_wins_x, m_wins_o;

    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic bit line3(input logic [8:0] c);
        for (int i = 0; i < 8; i++)
            if (c[lines[i][0]] && c[lines[i][1]] && c[lines[i][2]]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_closed(input int b);
        return m_wx[b] || m_wo[b] || (&(m_x[b*9 +: 9] | m_o[b*9 +: 9]));
    endfunction

    task automatic model_clear_board();
        m_x = '0; m_o = '0; m_wx = '0; m_wo = '0;
        m_forced = 9; m_turn = 0; m_go = 0; m_winner = 2'b00;
    endtask

    task automatic model_move(input int b, input int t, output int code);
        int idx;
        logic [8:0] sub, meta;
        bit all_closed;
        code = 2;
        if (b >= 0 && b <= 8 && t >= 0 && t <= 8 && !m_go) begin
            idx = b * 9 + t;
            if (!m_x[idx] && !m_o[idx] && !m_closed(b) && (m_forced == 9 || m_forced == b)) begin
                code = 1;
                if (m_turn) m_o[idx] = 1'b1; else m_x[idx] = 1'b1;
                sub = m_turn ? m_o[b*9 +: 9] : m_x[b*9 +: 9];
                if (line3(sub) && !m_wx[b] && !m_wo[b]) begin
                    if (m_turn) m_wo[b] = 1'b1; else m_wx[b] = 1'b1;
                end
                meta = m_turn ? m_wo : m_wx;
                all_closed = 1'b1;
                for (int k = 0; k < 9; k++) if (!m_closed(k)) all_closed = 1'b0;
                if (line3(meta)) begin
                    m_go = 1'b1;
                    if (m_turn) begin
                        m_winner = 2'b10;
                        if (m_wins_o < WMAX) m_wins_o++;
                    end else begin
                        m_winner = 2'b01;
                        if (m_wins_x < WMAX) m_wins_x++;
                    end
                end else if (all_closed) begin
                    m_go = 1'b1;
                    m_winner = 2'b11;
                end
                m_forced = (m_go || m_closed(t)) ? 9 : t;
                m_turn = !m_turn;
            end
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (move_ok || move_err) begin
            chk_eq("ok_err_exclusive", move_ok & move_err, 0);
            if (exp_q.size() == 0) chk_eq("unexpected_result", {move_ok, move_err}, 2'b00);
            else                   chk_eq("result_kind", move_ok ? 2'd1 : 2'd2, exp_q.pop_front());
        end
    end

    // driver tasks
    task automatic start_move(input int b, input int t);
        @(negedge clk);
        currBoard = 4'(b);
        currTile  = 4'(t);
        move      = 1'b1;
        @(negedge clk);
        move      = 1'b0;
    endtask

    task automatic new_game_pulse();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear_board();
    endtask

    task automatic check_state();
        chk_eq("X_state", X_state, m_x);
        chk_eq("O_state", O_state, m_o);
        chk_eq("board_won_x", board_won_x, m_wx);
        chk_eq("board_won_o", board_won_o, m_wo);
        chk_eq("forced_board", forced_board, m_forced);
        chk_eq("turn_o", turn_o, m_turn);
        chk_eq("game_over", game_over, m_go);
        chk_eq("winner", winner, m_winner);
        chk_eq("numWinsX", numWinsX, m_wins_x);
        chk_eq("numWinsO", numWinsO, m_wins_o);
        chk_eq("busy_idle", busy, 0);
    endtask

    task automatic check_reset_outputs();
        chk_eq("rst_X_state", X_state, 0);
        chk_eq("rst_O_state", O_state, 0);
        chk_eq("rst_won_x", board_won_x, 0);
        chk_eq("rst_won_o", board_won_o, 0);
        chk_eq("rst_forced", forced_board, 9);
        chk_eq("rst_turn", turn_o, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_move_ok", move_ok, 0);
        chk_eq("rst_move_err", move_err, 0);
        chk_eq("rst_game_over", game_over, 0);
        chk_eq("rst_winner", winner, 0);
        chk_eq("rst_winsX", numWinsX, 0);
        chk_eq("rst_winsO", numWinsO, 0);
        chk_eq("rst_state", dbg_state, 0);
    endtask

    task automatic do_move(input int b, input int t);
        int code, lat, busy_n;
        bit seen;
        model_move(b, t, code);
        exp_q.push_back(2'(code));
        start_move(b, t);
        lat = 0; busy_n = 0; seen = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            if (busy) busy_n++;
            if (!seen && (move_ok || move_err)) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        chk_eq("latency", lat, (code == 1) ? 4 : 1);
        chk_eq("busy_cycles", busy_n, (code == 1) ? 4 : 1);
        check_state();
    endtask

    int win_b [17] = '{0,1,0,2,0,1,4,2,4,3,4,6,8,1,8,3,8};
    int win_t [17] = '{1,0,2,0,0,4,0,4,3,4,6,8,0,8,3,8,6};

    task automatic play_win_game();
        for (int i = 0; i < 17; i++) do_move(win_b[i], win_t[i]);
    endtask

    initial begin
        int code;
        rst = 1'b1; move = 1'b0; new_game = 1'b0; currBoard = '0; currTile = '0;
        model_clear_board();
        m_wins_x = 0; m_wins_o = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();

        // first move, forced-board and occupancy rejections, sub-board win
        do_move(4, 4);
        chk_eq("x_bit40", X_state[40], 1);
        chk_eq("turn_after_first", turn_o, 1);
        chk_eq("forced_after_first", forced_board, 4);
        do_move(0, 0);
        do_move(4, 4);
        do_move(4, 0); do_move(0, 0); do_move(0, 4); do_move(4, 2);
        do_move(2, 0); do_move(0, 1); do_move(1, 0); do_move(0, 2);
        chk_eq("x_owns_b0", board_won_x[0], 1);
        do_move(2, 3); do_move(3, 0);
        chk_eq("forced_free_closed", forced_board, 9);
        do_move(0, 5);
        do_move(9, 1);
        do_move(5, 5);

        // move pulse while busy is dropped
        new_game_pulse();
        chk_eq("ng_state", dbg_state, 0);
        model_move(4, 4, code);
        exp_q.push_back(2'(code));
        start_move(4, 4);
        @(negedge clk);
        currBoard = 4'd0; currTile = 4'd0; move = 1'b1;
        @(negedge clk);
        move = 1'b0;
        repeat (5) @(negedge clk);
        check_state();
        chk_eq("busy_drop_queue", exp_q.size(), 0);

        // move and new_game together: move dropped, board cleared
        @(negedge clk);
        currBoard = 4'd1; currTile = 4'd1; move = 1'b1; new_game = 1'b1;
        @(negedge clk);
        move = 1'b0; new_game = 1'b0;
        model_clear_board();
        repeat (6) @(negedge clk);
        check_state();
        chk_eq("ng_move_board_clear", X_state | O_state, 0);

        // new_game aborts an in-flight move
        start_move(2, 2);
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear_board();
        repeat (4) @(negedge clk);
        check_state();

        // scripted meta win for X on boards 0, 4, 8
        play_win_game();
        chk_eq("win_winner", winner, 2'b01);
        chk_eq("win_game_over", game_over, 1);
        chk_eq("win_numWinsX", numWinsX, 1);
        do_move(5, 5);
        new_game_pulse();
        check_state();
        chk_eq("ng_keeps_tally", numWinsX, 1);
        chk_eq("ng_board_clear", X_state, 0);

        // drive the tally to saturation
        for (int g = 2; g <= WMAX; g++) begin
            new_game_pulse();
            play_win_game();
        end
        chk_eq("tally_at_max", numWinsX, WMAX);
        new_game_pulse();
        play_win_game();
        chk_eq("tally_saturated", numWinsX, WMAX);
        chk_eq("sat_winner", winner, 2'b01);

        // asynchronous reset during COMMIT
        new_game_pulse();
        do_move(4, 4);
        start_move(4, 0);
        @(negedge clk);
        chk_eq("pre_rst_in_commit", dbg_state, 2);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        model_clear_board();
        m_wins_x = 0; m_wins_o = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_move(4, 4);

        chk_eq("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
Turn and move controller for the ultimate tic-tac-toe game. It accepts a debounced move request at the cursor (board, tile) and validates it against the game rules. On a legal move it commits the mark into the 81-bit X/O occupancy vectors, resolves sub-board and meta-board wins, and computes the next forced board. It sits between the cursor logic/debouncers and the VGA/seven-segment display consumers, and maintains match tallies across games.

Parameters:
WINS_W, 7, width of the numWinsX/numWinsO tally counters (saturating).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset; clears all state including tallies
move  in  1  move request, one-cycle pulse (debounced)
new_game  in  1  synchronous pulse; clears the board but keeps tallies
currBoard  in  4  cursor sub-board 0-8
currTile  in  4  cursor tile 0-8
X_state  out  81  X occupancy; bit index = board*9 + tile
O_state  out  81  O occupancy; same indexing
board_won_x  out  9  sub-board owned by X
board_won_o  out  9  sub-board owned by O
forced_board  out  4  required board 0-8; 9 = free choice
turn_o  out  1  0 = X to move, 1 = O to move
busy  out  1  high while a move is in flight
move_ok  out  1  one-cycle pulse, legal move fully committed
move_err  out  1  one-cycle pulse, move rejected
game_over  out  1  game finished
winner  out  2  00 none, 01 X, 10 O, 11 draw
numWinsX  out  WINS_W  games won by X
numWinsO  out  WINS_W  games won by O

Behaviour:
- Reset values: X_state/O_state = 0, board_won_x/board_won_o = 0, forced_board = 9, turn_o = 0, busy = 0, move_ok = 0, move_err = 0, game_over = 0, winner = 00, tallies = 0, FSM = IDLE.
- FSM states: IDLE -> VALIDATE -> COMMIT -> SUB_CHECK -> META_CHECK -> IDLE.
- IDLE: on move, latch currBoard/currTile (cycle 0) and go to VALIDATE. busy is high from cycle 1 through cycle 4.
- VALIDATE (cycle 1): the move is legal iff all of the following hold:
  - board <= 8 and tile <= 8;
  - game_over = 0;
  - the target X and O bits are both 0;
  - the sub-board is not closed (closed = won by either player, or all 9 cells occupied);
  - forced_board = 9 or board = forced_board.
  If illegal: move_err pulses in cycle 1 and the FSM returns to IDLE. Nothing else changes. If legal: go to COMMIT.
- COMMIT (cycle 2): set the bit in X_state if turn_o = 0, else in O_state.
- SUB_CHECK (cycle 3): evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) of the written sub-board for the mover only.
  - On a line, set that player's board_won bit.
  - An owned sub-board is never re-owned.
  - A full sub-board with no line stays unowned but is closed.
- META_CHECK (cycle 4):
  - Evaluate the 8 lines over the mover's board_won vector.
  - On a line: game_over = 1, winner = mover, and the mover's tally increments, saturating at 2^WINS_W-1.
  - Otherwise, if all 9 sub-boards are closed: game_over = 1, winner = 11, no tally change.
  - forced_board = latched tile, or 9 if that sub-board is now closed or game_over is set.
  - turn_o toggles.
  - move_ok pulses. All outputs are stable and updated in this same cycle.
- Fixed latency: move sampled at cycle 0 -> move_ok at cycle 4 -> next move accepted from cycle 5.
- A move pulse while busy is dropped silently, with no move_err.
- new_game (any state):
  - Next cycle: X/O state, board_won, game_over, winner clear; forced_board = 9; turn_o = 0; FSM -> IDLE; busy = 0. Tallies are held.
  - An in-flight move is aborted with no move_ok.
  - new_game has priority over a simultaneous move; that move is dropped.
- rst asserted mid-operation: all outputs go to their reset values immediately (asynchronous), and move_ok/move_err are suppressed.
- move_ok and move_err are never high in the same cycle.

Test Plan:
- Reset, then move at board 4 tile 4 -> move_ok 4 cycles later; X_state bit 40 = 1; turn_o = 1; forced_board = 4; busy high for exactly 4 cycles.
- After that, O moves at board 0 tile 0 while forced_board = 4 -> move_err in cycle 1; all state unchanged. O then moves at board 4 tile 4 -> move_err (occupied).
- X fills tiles 0, 1, 2 of board 0 (O plays elsewhere legally) -> board_won_x[0] = 1. A later move sent to board 0 -> forced_board = 9. A move into board 0 -> move_err.
- Scripted game where X owns boards 0, 4, 8 -> winner = 01, game_over = 1, numWinsX = 1. Next move -> move_err. new_game -> board cleared, numWinsX still 1.
- Move pulse during busy, and move + new_game in the same cycle -> neither produces move_ok or move_err; board is clear after new_game.
- Preload numWinsX = 127 via repeated X wins (or force), then X wins again -> numWinsX stays 127. Assert rst mid-COMMIT -> all outputs zero/reset immediately, tallies = 0.
